// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - sequencing controller for the repeated-addition multiplier datapath
//
// Captures an operand pair on start, then drives the datapath operand bus and the
// load/clear/decrement strobes until the datapath B counter reaches zero. A shadow
// iteration counter is checked against the datapath zero flag on every ACC cycle.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, a_in, b_in   operand request, sampled only while idle
//   done_ack            consumer acknowledge of done
//   abort               synchronous cancel of a running operation
//   eqz                 datapath flag: B register == 0
//   data_out            datapath operand bus
//   LdA, LdB, LdP       datapath load strobes
//   clrP, decB          datapath clear-product / decrement-B strobes
//   busy, done          status
//   err, aborted        single-cycle event pulses
module mul_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             done_ack,
    input  logic             abort,
    input  logic             eqz,
    output logic [WIDTH-1:0] data_out,
    output logic             LdA,
    output logic             LdB,
    output logic             LdP,
    output logic             clrP,
    output logic             decB,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             aborted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_ACC    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] cnt;
    logic             cnt_zero;
    logic             accept;

    assign cnt_zero = (cnt == '0);
    assign accept   = (state == S_IDLE) && start;
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        data_out  = '0;
        LdA       = 1'b0;
        LdB       = 1'b0;
        LdP       = 1'b0;
        clrP      = 1'b0;
        decB      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        aborted   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                data_out  = a_q;
                LdA       = 1'b1;
                state_nxt = S_LOAD_B;
            end
            S_LOAD_B: begin
                data_out  = b_q;
                LdB       = 1'b1;
                clrP      = 1'b1;
                state_nxt = S_ACC;
            end
            S_ACC: begin
                if (!eqz && !cnt_zero) begin
                    LdP  = 1'b1;
                    decB = 1'b1;
                end else if (eqz && cnt_zero) begin
                    state_nxt = S_DONE;
                end else begin
                    // Datapath zero flag and shadow count disagree: bail out
                    // rather than accumulate forever or stop early silently.
                    err       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (done_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Abort wins over every decode above once an operation is running.
        if (abort && (state != S_IDLE)) begin
            data_out  = '0;
            LdA       = 1'b0;
            LdB       = 1'b0;
            LdP       = 1'b0;
            clrP      = 1'b0;
            decB      = 1'b0;
            done      = 1'b0;
            err       = 1'b0;
            aborted   = 1'b1;
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q <= a_in;
                b_q <= b_in;
            end
            // Shadow counter tracks the datapath B register: loaded alongside
            // LdB, decremented alongside decB.
            if (LdB) begin
                cnt <= b_q;
            end else if (decB) begin
                cnt <= cnt - ONE;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl with a behavioural datapath
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        done_ack;
    logic        abort;
    logic        eqz;
    logic [15:0] data_out;
    logic        LdA;
    logic        LdB;
    logic        LdP;
    logic        clrP;
    logic        decB;
    logic        busy;
    logic        done;
    logic        err;
    logic        aborted;

    mul_seq_ctrl #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .done_ack (done_ack),
        .abort    (abort),
        .eqz      (eqz),
        .data_out (data_out),
        .LdA      (LdA),
        .LdB      (LdB),
        .LdP      (LdP),
        .clrP     (clrP),
        .decB     (decB),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .aborted  (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural datapath: A, B, P registers driven by the controller strobes.
    logic [15:0] dp_a = 16'd0;
    logic [15:0] dp_b = 16'd0;
    logic [15:0] dp_p = 16'd0;
    logic [1:0]  eqz_sel = 2'd0;   // 0 real flag, 1 stuck at 1, 2 stuck at 0

    always @(posedge clk) begin
        if (LdA) dp_a <= data_out;
        if (LdB) dp_b <= data_out;
        else if (decB) dp_b <= dp_b - 16'd1;
        if (clrP) dp_p <= 16'd0;
        else if (LdP) dp_p <= dp_p + dp_a;
    end

    assign eqz = (eqz_sel == 2'd1) ? 1'b1 : (eqz_sel == 2'd2) ? 1'b0 : (dp_b == 16'd0);

    logic [24:0] out_vec;
    assign out_vec = {data_out, LdA, LdB, LdP, clrP, decB, busy, done, err, aborted};

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scenario knobs (relative cycle k: k=1 is the cycle after start is accepted).
    int abort_at;
    int rst_at;
    int ack_hold;
    int fault_at;
    logic [1:0] fault_mode;
    bit start_in_done;

    // Observations of one operation.
    int lda_cnt, lda_cyc, ldb_cnt, ldb_cyc, clrp_cyc, ldp_cnt, ldp_first, ldp_last;
    int pair_bad, done_cnt, done_first, err_cyc, err_strobes, abort_cyc, abort_strobes, idle_cyc;
    logic [15:0] lda_data, ldb_data;
    logic [24:0] idle_vec;

    task automatic clear_knobs();
        abort_at = -1; rst_at = -1; ack_hold = 0; fault_at = -1;
        fault_mode = 2'd0; start_in_done = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b);
        int k;
        lda_cnt = 0; lda_cyc = -1; ldb_cnt = 0; ldb_cyc = -1; clrp_cyc = -1;
        ldp_cnt = 0; ldp_first = -1; ldp_last = -1; pair_bad = 0;
        done_cnt = 0; done_first = -1; err_cyc = -1; err_strobes = 0;
        abort_cyc = -1; abort_strobes = 0; idle_cyc = -1; idle_vec = '0;
        lda_data = '0; ldb_data = '0;

        @(negedge clk);
        a_in = a; b_in = b; start = 1'b1;
        k = 1;
        forever begin
            @(posedge clk); #1;
            abort    = (k == abort_at);
            rst_n    = (k != rst_at);
            eqz_sel  = (fault_at >= 0 && k >= fault_at) ? fault_mode : 2'd0;
            done_ack = (ack_hold == 0) ? 1'b1 : (done_first >= 0 && k >= done_first + ack_hold);
            start    = start_in_done && done_first >= 0 && k < done_first + ack_hold;
            a_in     = 16'($urandom);
            b_in     = 16'($urandom);
            @(negedge clk);
            if (LdA) begin lda_cnt++; lda_cyc = k; lda_data = data_out; end
            if (LdB) begin ldb_cnt++; ldb_cyc = k; ldb_data = data_out; end
            if (clrP) clrp_cyc = k;
            if (LdP) begin
                ldp_cnt++;
                if (ldp_first < 0) ldp_first = k;
                ldp_last = k;
            end
            if (LdP != decB) pair_bad++;
            if (done) begin
                done_cnt++;
                if (done_first < 0) done_first = k;
            end
            if (err) begin
                err_cyc = k;
                err_strobes = int'(LdA | LdB | LdP | clrP | decB);
            end
            if (aborted) begin
                abort_cyc = k;
                abort_strobes = int'(LdA | LdB | LdP | clrP | decB);
            end
            if (!busy) begin
                idle_cyc = k;
                idle_vec = out_vec;
                break;
            end
            if (k >= 400) begin
                check("timeout", 32'd1, 32'd0);
                break;
            end
            k++;
        end
        start = 1'b0; abort = 1'b0; done_ack = 1'b0; rst_n = 1'b1; eqz_sel = 2'd0;
    endtask

    // A completed multiply: expectations follow directly from the cycle schedule.
    task automatic check_complete(input string tag, input logic [15:0] a, input logic [15:0] b);
        int ib;
        logic [31:0] prod;
        ib = int'(b);
        prod = 32'(a) * 32'(b);
        check({tag, ".lda_cyc"}, lda_cyc, 1);
        check({tag, ".lda_cnt"}, lda_cnt, 1);
        check({tag, ".lda_data"}, lda_data, a);
        check({tag, ".ldb_cyc"}, ldb_cyc, 2);
        check({tag, ".ldb_cnt"}, ldb_cnt, 1);
        check({tag, ".ldb_data"}, ldb_data, b);
        check({tag, ".clrp_cyc"}, clrp_cyc, 2);
        check({tag, ".ldp_cnt"}, ldp_cnt, ib);
        if (ib > 0) begin
            check({tag, ".ldp_first"}, ldp_first, 3);
            check({tag, ".ldp_last"}, ldp_last, 2 + ib);
        end
        check({tag, ".pair"}, pair_bad, 0);
        check({tag, ".done_first"}, done_first, 4 + ib);
        check({tag, ".done_cnt"}, done_cnt, ack_hold + 1);
        check({tag, ".idle_cyc"}, idle_cyc, 5 + ib + ack_hold);
        check({tag, ".idle_out"}, idle_vec, 25'd0);
        check({tag, ".err"}, err_cyc, -1);
        check({tag, ".aborted"}, abort_cyc, -1);
        check({tag, ".product"}, dp_p, prod[15:0]);
    endtask

    // Idle cycles: ack and abort wiggle but every output must stay 0.
    task automatic quiet(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            done_ack = 1'($urandom);
            abort    = 1'($urandom);
            @(negedge clk);
            check(tag, out_vec, 25'd0);
        end
        done_ack = 1'b0; abort = 1'b0;
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; done_ack = 1'b0; abort = 1'b0;
        clear_knobs();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.out", out_vec, 25'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset.out", out_vec, 25'd0);
        quiet("idle_quiet", 3);

        // Nominal, ack tied high.
        clear_knobs();
        run_op(16'd7, 16'd3);
        check_complete("nominal", 16'd7, 16'd3);

        // Zero multiplier.
        run_op(16'hFFFF, 16'd0);
        check_complete("zero_b", 16'hFFFF, 16'd0);

        // Backpressure with start pulses during DONE.
        ack_hold = 10; start_in_done = 1'b1;
        run_op(16'd5, 16'd2);
        check_complete("backpressure", 16'd5, 16'd2);
        quiet("bp_quiet", 3);

        // Randomized operands and ack delays.
        for (int i = 0; i < 12; i++) begin
            clear_knobs();
            ack_hold = int'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom_range(0, 24));
            run_op(ra, rb);
            check_complete("random", ra, rb);
        end

        // Abort at the 20th ACC cycle, then a clean operation.
        clear_knobs();
        abort_at = 22;
        run_op(16'd3, 16'd100);
        check("abort.cyc", abort_cyc, 22);
        check("abort.strobes", abort_strobes, 0);
        check("abort.idle", idle_cyc, 23);
        check("abort.done", done_cnt, 0);
        check("abort.ldp", ldp_cnt, 19);
        check("abort.err", err_cyc, -1);
        clear_knobs();
        run_op(16'd2, 16'd4);
        check_complete("after_abort", 16'd2, 16'd4);

        // eqz forced high while the shadow count is 5 (b=8: cnt=5 at k=6).
        clear_knobs();
        fault_mode = 2'd1; fault_at = 6;
        run_op(16'd9, 16'd8);
        check("eqz1.err_cyc", err_cyc, 6);
        check("eqz1.strobes", err_strobes, 0);
        check("eqz1.idle", idle_cyc, 7);
        check("eqz1.done", done_cnt, 0);
        check("eqz1.ldp", ldp_cnt, 3);
        check("eqz1.aborted", abort_cyc, -1);

        // eqz stuck low with b=2: count hits zero at k=5.
        clear_knobs();
        fault_mode = 2'd2; fault_at = 1;
        run_op(16'd4, 16'd2);
        check("eqz0.err_cyc", err_cyc, 5);
        check("eqz0.strobes", err_strobes, 0);
        check("eqz0.idle", idle_cyc, 6);
        check("eqz0.done", done_cnt, 0);
        check("eqz0.ldp", ldp_cnt, 2);

        // Reset during the 10th ACC iteration.
        clear_knobs();
        rst_at = 12;
        run_op(16'd11, 16'd50);
        check("rst.idle", idle_cyc, 13);
        check("rst.out", idle_vec, 25'd0);
        check("rst.ldp", ldp_cnt, 10);
        check("rst.done", done_cnt, 0);
        check("rst.err", err_cyc, -1);
        check("rst.aborted", abort_cyc, -1);
        quiet("rst_quiet", 6);
        clear_knobs();
        run_op(16'd9, 16'd5);
        check_complete("after_reset", 16'd9, 16'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
